// File: rtl/dmem_banked.sv
// Byte-banked data memory behind the load/store unit.
// One request per cycle over a valid/ready port. Reads are pipelined by READ_LAT
// stages. Out-of-range word indices are reported through rsp_err. After reset,
// a clear sweep writes INIT_VAL to every location before any request is accepted.
module dmem_banked #(
    parameter int         N_BANKS  = 4,
    parameter int         DEPTH    = 1024,
    parameter int         ADDR_W   = 32,
    parameter int         READ_LAT = 1,
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      daddr,
    input  logic [8*N_BANKS-1:0]   dwdata,
    input  logic [N_BANKS-1:0]     dwe,
    output logic                   rsp_valid,
    output logic [8*N_BANKS-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic                   init_done
);

    localparam int DATA_W = 8 * N_BANKS;
    localparam int OFF_W  = $clog2(N_BANKS);
    localparam int WIDX_W = ADDR_W - OFF_W;
    localparam int IDX_W  = $clog2(DEPTH);

    // The depth is widened by one bit so that the range check uses the full
    // word index and never aliases a high address onto a low word.
    localparam logic [WIDX_W:0]  DEPTH_EXT = (WIDX_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     clr_cnt;

    logic [7:0]           mem [N_BANKS][DEPTH];

    logic [WIDX_W-1:0]    word_idx;
    logic [IDX_W-1:0]     mem_idx;
    logic                 in_range;
    logic                 is_write;
    logic                 accept;
    logic [DATA_W-1:0]    rd_word;

    logic [READ_LAT-1:0]  pipe_valid;
    logic [READ_LAT-1:0]  pipe_err;
    logic [DATA_W-1:0]    pipe_data [READ_LAT];

    assign word_idx = daddr[ADDR_W-1:OFF_W];
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign in_range = {1'b0, word_idx} < DEPTH_EXT;
    assign is_write = |dwe;
    assign accept   = req_valid & req_ready;

    // The byte offset inside a word is ignored; the whole word is always returned.
    generate
        if (OFF_W > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^daddr[OFF_W-1:0];
        end
    endgenerate

    // State register: reset always restarts the clear sweep.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs: leave INIT on the edge that clears the last word.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        init_done = 1'b0;
        case (state)
            S_INIT: begin
                if (clr_cnt == LAST_IDX) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
        endcase
    end

    // Clear-sweep counter: one word per cycle while in INIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt <= '0;
        end else if (state == S_INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Array writes: clear sweep in INIT, masked lane writes for accepted in-range stores.
    // NOTE: the array has no reset; its contents are defined by the clear sweep instead.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            for (int k = 0; k < N_BANKS; k++) begin
                mem[k][clr_cnt] <= INIT_VAL;
            end
        end else if (accept && is_write && in_range) begin
            for (int k = 0; k < N_BANKS; k++) begin
                if (dwe[k]) begin
                    mem[k][mem_idx] <= dwdata[8*k +: 8];
                end
            end
        end
    end

    // Assemble the addressed word from all byte lanes.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < N_BANKS; k++) begin
            rd_word[8*k +: 8] = mem[k][mem_idx];
        end
    end

    // Response pipeline: valid shifts every cycle, payload moves only with a valid
    // entry, so the output payload holds between responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            if (accept) begin
                pipe_data[0] <= (!is_write && in_range) ? rd_word : '0;
                pipe_err[0]  <= !in_range;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                    pipe_err[i]  <= pipe_err[i-1];
                end
            end
        end
    end

    assign rsp_valid = pipe_valid[READ_LAT-1];
    assign rsp_rdata = pipe_data[READ_LAT-1];
    assign rsp_err   = pipe_err[READ_LAT-1];

endmodule

// File: doc/dmem_banked.md
# dmem_banked

Parametrised byte-banked data memory with a valid/ready request port, configurable read latency and hardware clear-on-reset. It sits behind the CPU load/store unit at the data address map base. It generalises the fixed 4-bank, combinational-read data memory to N byte lanes, arbitrary depth, pipelined synchronous reads, out-of-range error reporting and a self-clearing init sequence.

## Interface
- N_BANKS, 4: byte lanes per word; DATA_W = 8*N_BANKS
- DEPTH, 1024: words per bank; power of two, ≥ 2
- ADDR_W, 32: byte-address width
- READ_LAT, 1: cycles from request acceptance to response, 1..4
- INIT_VAL, 8'h00: byte value written to every location during init

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; reset = 0 holds block in reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts request this cycle
- daddr  in  ADDR_W  byte address; word index = daddr[ADDR_W-1:log2(N_BANKS)], low bits ignored
- dwdata  in  DATA_W  write data, lane k = dwdata[8k+7:8k]
- dwe  in  N_BANKS  per-lane write mask; all-zero = read
- rsp_valid  out  1  response valid, one-cycle pulse per accepted request
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  word index ≥ DEPTH for the responded request
- init_done  out  1  clear sweep finished

## Operation
- States: INIT, RUN. Async reset forces INIT, clear counter = 0, read pipeline flushed.
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, init_done 0.
- INIT: each cycle with reset = 1 writes INIT_VAL to all lanes of word[counter], counter += 1. The edge writing DEPTH-1 moves to RUN; init_done and req_ready read 1 from the next cycle. Requests are ignored in INIT.
- RUN: req_ready = 1 constantly. Acceptance = req_valid & req_ready at posedge.
- Write (dwe ≠ 0), in range: lanes with dwe[k] = 1 updated at the accept edge; other lanes unchanged. Response: rsp_valid, rsp_rdata = 0, rsp_err = 0.
- Read (dwe = 0), in range: full word captured at the accept edge into pipeline stage 1, then shifted one stage per cycle.
- Out of range (index ≥ DEPTH; only possible when DEPTH < 2^(ADDR_W-log2 N_BANKS)): no array write, rsp_rdata = 0, rsp_err = 1.
- Index computed with full width before comparison; no wrap-around aliasing.
- Sub-word extraction and sign extension are the CPU's job; the block always returns the whole word.

## Timing
- One request accepted per cycle, back-to-back, no bubbles.
- Response for a request accepted at edge E is valid during the cycle after edge E+READ_LAT-1. For READ_LAT = 1, the response appears the cycle after acceptance.
- Responses are strictly in acceptance order. rsp_valid is low in every cycle without a matching acceptance. rsp_rdata/rsp_err hold their last value when rsp_valid = 0.
- Read-after-write: a read accepted one or more edges after a write to the same word returns the new data. No same-edge conflict is possible.
- No response backpressure; the consumer must sink every rsp_valid.
- Reset asserted mid-operation: in-flight responses are dropped (rsp_valid 0 immediately, asynchronously). Array contents are re-cleared by a full INIT sweep after release.
- INIT duration: exactly DEPTH cycles after reset release before the first acceptance.

## Test plan
- Init: fill words 0..3 with 32'hFFFFFFFF, pulse reset, wait init_done → read word 3 returns 32'h00000000, and req_ready rises exactly DEPTH cycles after release.
- Full write/read, READ_LAT = 2: write 32'hDEADBEEF at 0x10, read 0x10 next cycle → rsp_valid 2 cycles after read accept, rsp_rdata = 32'hDEADBEEF, rsp_err 0.
- Byte mask: over 32'h11223344 at 0x20, write dwe = 4'b0101, dwdata = 32'hAABBCCDD → read gives 32'h11BB33DD.
- Out of range, DEPTH = 1024, ADDR_W = 32: write 32'h12345678 at 0x1000, then read 0x1000 → both responses have rsp_err 1, rsp_rdata 0; word 0 is still its init value.
- Streaming: 8 back-to-back writes 0x0..0x1C (data = index), then 8 back-to-back reads → 16 consecutive rsp_valid cycles, read data 0..7 in order.
- Reset mid-stream: assert reset while 2 reads are in flight → no rsp_valid for them, and rsp_valid stays 0 until after the new INIT sweep completes.
